strided_range_counter: RTL and testbench
========================================

# strided_range_counter

Parametrised successor to the team's increment-then-stop counter. It walks a value from a start bound to an end bound in a programmable stride, with either stop-at-end or wrap-to-start modes. Each value is presented on a valid/ready stream, and the block reports last, done, wrap and completed-pass status. It feeds the address and loop-index generators that drive the weight and pixel buffers.

## Interface
Parameters:
- Bits, 8, width of count, bounds and stride
- PassBits, 8, width of the saturating completed-pass counter

Ports:
- clk_i  in  1  clock; all state changes on its rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- load_i  in  1  synchronous (re)start; samples configuration
- start_val_i  in  Bits  first value of a pass
- end_val_i  in  Bits  inclusive upper bound
- step_i  in  Bits  stride; 0 is treated as 1
- wrap_i  in  1  mode: 0 = stop at end, 1 = wrap to start
- ready_i  in  1  consumer accepts count_o this cycle
- count_o  out  Bits  current value
- valid_o  out  1  count_o is offered
- last_o  out  1  count_o is the final value of the current pass
- done_o  out  1  stop-mode sequence complete
- wrap_o  out  1  one-cycle pulse on every wrap
- passes_o  out  PassBits  completed passes, saturating
- cfg_err_o  out  1  one-cycle pulse on a rejected load

## Operation
- Configuration registers (start, end, step, wrap) are written only on an accepted load. Input changes at any other time have no effect.
- States:
  - IDLE: valid_o=0, done_o=0
  - RUN: valid_o=1
  - DONE: valid_o=0, done_o=1
- load_i in any state:
  - If end_val_i < start_val_i: pulse cfg_err_o and go to IDLE. count_o, passes_o and configuration are unchanged.
  - Otherwise: count_o<=start_val_i, passes_o<=0, go to RUN.
- Accept = valid_o && ready_i && !load_i.
- Next value is computed at Bits+1 width: sum = count_o + eff_step, where eff_step = (step==0) ? 1 : step. This prevents overflow from aliasing past the end bound.
- last_o = valid_o && (sum > {1'b0,end}). Combinational from registers only; it does not depend on ready_i.
- Accept with !last_o: count_o <= sum[Bits-1:0].
- Accept with last_o in stop mode:
  - count_o holds its value
  - passes_o increments
  - state goes to DONE
- Accept with last_o in wrap mode:
  - count_o <= start
  - passes_o increments
  - wrap_o=1 for the following cycle
  - state stays RUN
- passes_o saturates at all-ones and does not roll over.
- DONE is left only by load_i or reset. ready_i is ignored in IDLE and DONE.
- Priority: reset > load_i > accept.

## Timing
- Reset values, applied asynchronously when rst_ni falls:
  - state IDLE
  - count_o=0, passes_o=0
  - valid_o, last_o, done_o, wrap_o, cfg_err_o = 0
  - configuration registers = 0, wrap mode = 0
- Reset release is synchronous to clk_i. The first load is honoured on the first rising edge with rst_ni high.
- Load latency: load_i high at edge N → count_o=start and valid_o=1 immediately after edge N.
- Throughput: one value per cycle while ready_i stays high. count_o is stable while valid_o && !ready_i.
- wrap_o and cfg_err_o are registered pulses exactly one cycle wide, asserted in the cycle after the triggering edge.
- done_o rises in the cycle after the final accept, in the same cycle valid_o falls.
- Single-value pass (start==end, or start+step>end): last_o=1 from the first cycle of RUN.
- Reset mid-run takes effect immediately, without waiting for a clock edge. No accept is recorded for the interrupted cycle.

## Test plan
- Stop mode: start=3, end=10, step=3, ready_i=1.
  - count_o must be 3, 6, 9, with last_o only at 9.
  - Then valid_o=0, done_o=1, passes_o=1, count_o holds 9.
- Wrap mode: start=0, end=4, step=2, ready_i=1 for 7 cycles.
  - count_o must be 0, 2, 4, 0, 2, 4, 0.
  - wrap_o must pulse after each 4; passes_o must end at 2.
- Backpressure: stop mode, start=5, end=8, step=1. Toggle ready_i every cycle.
  - count_o changes only on cycles where ready_i is high; the sequence must be 5, 6, 7, 8.
  - last_o must be held high while 8 is stalled.
- Overflow: Bits=8, start=0xF0, end=0xFF, step=0x20.
  - count_o must be 0xF0 with last_o=1 immediately.
  - After the accept, done_o=1 and count_o never shows 0x10.
  - Repeat with step=0: the sequence must be 0xF0..0xFF.
- Load and error:
  - load_i asserted in the same cycle as an accept → count_o=new start; no increment and no pass are counted.
  - Load with end=2, start=9 → cfg_err_o pulses one cycle and valid_o=0.
  - passes_o must saturate at 0xFF when PassBits=8 (wrap start=end=1, ready_i high for 300 cycles).
- Async reset: drop rst_ni mid-cycle during RUN at count 0x40.
  - All outputs must go to their reset values before the next edge.
  - After release with no load, valid_o must stay 0.

Source files
------------

// File: rtl/strided_range_counter.sv
// Strided range counter: walks start..end (inclusive) in a programmable stride,
// presenting each value on a valid/ready stream with stop-at-end or wrap modes.
module strided_range_counter #(
    parameter int unsigned Bits     = 8,
    parameter int unsigned PassBits = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                load_i,
    input  logic [Bits-1:0]     start_val_i,
    input  logic [Bits-1:0]     end_val_i,
    input  logic [Bits-1:0]     step_i,
    input  logic                wrap_i,
    input  logic                ready_i,
    output logic [Bits-1:0]     count_o,
    output logic                valid_o,
    output logic                last_o,
    output logic                done_o,
    output logic                wrap_o,
    output logic [PassBits-1:0] passes_o,
    output logic                cfg_err_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [Bits-1:0]       count_q, count_d;
    logic [PassBits-1:0]   passes_q, passes_d;
    logic [Bits-1:0]       start_q, start_d;
    logic [Bits-1:0]       end_q, end_d;
    logic [Bits-1:0]       step_q, step_d;
    logic                  wrap_mode_q, wrap_mode_d;
    logic                  wrap_pulse_q, wrap_pulse_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  valid_q, done_q;

    logic [Bits-1:0]       eff_step_c;
    logic [Bits:0]         sum_c;
    logic                  last_c;
    logic                  accept_c;

    // Next value is formed one bit wider so a carry can never alias back below end.
    assign eff_step_c = (step_q == '0) ? Bits'(1) : step_q;
    assign sum_c      = {1'b0, count_q} + {1'b0, eff_step_c};
    assign last_c     = valid_q && (sum_c > {1'b0, end_q});
    assign accept_c   = valid_q && ready_i && !load_i;

    // Next-state and datapath update; load takes priority over accept.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        passes_d     = passes_q;
        start_d      = start_q;
        end_d        = end_q;
        step_d       = step_q;
        wrap_mode_d  = wrap_mode_q;
        wrap_pulse_d = 1'b0;
        cfg_err_d    = 1'b0;

        if (load_i) begin
            if (end_val_i < start_val_i) begin
                cfg_err_d = 1'b1;
                state_d   = IDLE;
            end else begin
                start_d     = start_val_i;
                end_d       = end_val_i;
                step_d      = step_i;
                wrap_mode_d = wrap_i;
                count_d     = start_val_i;
                passes_d    = '0;
                state_d     = RUN;
            end
        end else if (accept_c) begin
            if (!last_c) begin
                count_d = sum_c[Bits-1:0];
            end else begin
                passes_d = (passes_q == '1) ? passes_q : passes_q + PassBits'(1);
                if (wrap_mode_q) begin
                    count_d      = start_q;
                    wrap_pulse_d = 1'b1;
                end else begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            count_q      <= '0;
            passes_q     <= '0;
            start_q      <= '0;
            end_q        <= '0;
            step_q       <= '0;
            wrap_mode_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            passes_q     <= passes_d;
            start_q      <= start_d;
            end_q        <= end_d;
            step_q       <= step_d;
            wrap_mode_q  <= wrap_mode_d;
            wrap_pulse_q <= wrap_pulse_d;
            cfg_err_q    <= cfg_err_d;
            valid_q      <= (state_d == RUN);
            done_q       <= (state_d == DONE);
        end
    end

    assign count_o   = count_q;
    assign valid_o   = valid_q;
    assign last_o    = last_c;
    assign done_o    = done_q;
    assign wrap_o    = wrap_pulse_q;
    assign passes_o  = passes_q;
    assign cfg_err_o = cfg_err_q;

endmodule

// File: tb/tb_strided_range_counter.sv
// Bench for strided_range_counter: directed scenarios plus random traffic,
// all compared every cycle against an integer reference model of the counter.
module tb_strided_range_counter;

    localparam int unsigned Bits     = 8;
    localparam int unsigned PassBits = 8;

    logic                clk;
    logic                rst_ni;
    logic                load_i;
    logic [Bits-1:0]     start_val_i;
    logic [Bits-1:0]     end_val_i;
    logic [Bits-1:0]     step_i;
    logic                wrap_i;
    logic                ready_i;
    logic [Bits-1:0]     count_o;
    logic                valid_o;
    logic                last_o;
    logic                done_o;
    logic                wrap_o;
    logic [PassBits-1:0] passes_o;
    logic                cfg_err_o;

    strided_range_counter #(.Bits(Bits), .PassBits(PassBits)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .load_i     (load_i),
        .start_val_i(start_val_i),
        .end_val_i  (end_val_i),
        .step_i     (step_i),
        .wrap_i     (wrap_i),
        .ready_i    (ready_i),
        .count_o    (count_o),
        .valid_o    (valid_o),
        .last_o     (last_o),
        .done_o     (done_o),
        .wrap_o     (wrap_o),
        .passes_o   (passes_o),
        .cfg_err_o  (cfg_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase 0=idle 1=running 2=finished, values as plain integers.
    int m_phase, m_count, m_passes, m_start, m_end, m_step, m_wrap;
    int m_wrap_pulse, m_err;

    function automatic int eff(input int s);
        return (s == 0) ? 1 : s;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_count = 0; m_passes = 0;
        m_start = 0; m_end = 0; m_step = 0; m_wrap = 0;
        m_wrap_pulse = 0; m_err = 0;
    endtask

    task automatic model_edge();
        m_wrap_pulse = 0;
        m_err        = 0;
        if (load_i) begin
            if (int'(end_val_i) < int'(start_val_i)) begin
                m_err   = 1;
                m_phase = 0;
            end else begin
                m_start = start_val_i; m_end = end_val_i;
                m_step  = step_i;      m_wrap = wrap_i;
                m_count = start_val_i; m_passes = 0;
                m_phase = 1;
            end
        end else if (m_phase == 1 && ready_i) begin
            if (m_count + eff(m_step) > m_end) begin
                if (m_passes < 255) m_passes = m_passes + 1;
                if (m_wrap != 0) begin
                    m_count      = m_start;
                    m_wrap_pulse = 1;
                end else begin
                    m_phase = 2;
                end
            end else begin
                m_count = m_count + eff(m_step);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int exp_last;
        exp_last = (m_phase == 1 && (m_count + eff(m_step) > m_end)) ? 1 : 0;
        chk("count",   32'(count_o),   32'(m_count));
        chk("valid",   32'(valid_o),   32'(m_phase == 1));
        chk("last",    32'(last_o),    32'(exp_last));
        chk("done",    32'(done_o),    32'(m_phase == 2));
        chk("wrap",    32'(wrap_o),    32'(m_wrap_pulse));
        chk("passes",  32'(passes_o),  32'(m_passes));
        chk("cfg_err", 32'(cfg_err_o), 32'(m_err));
    endtask

    task automatic drive(input logic ld, input int sv, input int ev, input int st,
                         input logic wm, input logic rdy);
        load_i      = ld;
        start_val_i = Bits'(sv);
        end_val_i   = Bits'(ev);
        step_i      = Bits'(st);
        wrap_i      = wm;
        ready_i     = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_ni) model_edge();
        #1;
        check_outputs();
    endtask

    initial begin
        int wrap_seq [7];
        wrap_seq = '{0, 2, 4, 0, 2, 4, 0};

        // Reset state
        rst_ni = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        model_reset();
        #12;
        check_outputs();
        rst_ni = 1'b1;
        tick();

        // Stop mode 3..10 step 3
        drive(1, 3, 10, 3, 0, 1);
        tick();
        chk("stop_first", 32'(count_o), 32'd3);
        drive(0, 99, 1, 7, 1, 1);
        tick();
        chk("stop_second", 32'(count_o), 32'd6);
        tick();
        chk("stop_third", 32'(count_o), 32'd9);
        chk("stop_last", 32'(last_o), 32'd1);
        tick();
        chk("stop_done", 32'(done_o), 32'd1);
        chk("stop_hold", 32'(count_o), 32'd9);
        chk("stop_passes", 32'(passes_o), 32'd1);
        tick();

        // Wrap mode 0..4 step 2
        drive(1, 0, 4, 2, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        chk("wrap_seq0", 32'(count_o), 32'(wrap_seq[0]));
        for (int i = 1; i < 7; i++) begin
            tick();
            chk("wrap_seq", 32'(count_o), 32'(wrap_seq[i]));
        end
        chk("wrap_passes", 32'(passes_o), 32'd2);

        // Backpressure 5..8 step 1, ready toggling
        drive(1, 5, 8, 1, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, 0, 0, 0, 0, logic'(i % 2));
            tick();
        end
        chk("bp_done", 32'(done_o), 32'd1);
        chk("bp_count", 32'(count_o), 32'd8);

        // Load coincident with an accept
        drive(1, 8'h10, 8'h30, 4, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(1, 8'h20, 8'h30, 1, 0, 1);
        tick();
        chk("load_acc_count", 32'(count_o), 32'h20);
        chk("load_acc_passes", 32'(passes_o), 32'd0);

        // Overflow guard
        drive(1, 8'hF0, 8'hFF, 8'h20, 0, 1);
        tick();
        chk("ovf_last", 32'(last_o), 32'd1);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("ovf_done", 32'(done_o), 32'd1);
        chk("ovf_count", 32'(count_o), 32'hF0);
        drive(1, 8'hF0, 8'hFF, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) tick();
        chk("step0_count", 32'(count_o), 32'hFF);
        chk("step0_done", 32'(done_o), 32'd1);

        // Rejected load
        drive(1, 9, 2, 1, 0, 1);
        tick();
        chk("err_pulse", 32'(cfg_err_o), 32'd1);
        chk("err_valid", 32'(valid_o), 32'd0);
        drive(0, 0, 0, 0, 0, 1);
        tick();
        chk("err_clear", 32'(cfg_err_o), 32'd0);

        // Pass counter saturation
        drive(1, 1, 1, 0, 1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 300; i++) tick();
        chk("sat_passes", 32'(passes_o), 32'hFF);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive(logic'($urandom_range(0, 11) == 0),
                  int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 40)),
                  logic'($urandom_range(0, 1)), logic'($urandom_range(0, 3) != 0));
            tick();
        end

        // Asynchronous reset mid-run
        drive(1, 8'h40, 8'h80, 1, 0, 0);
        tick();
        chk("arst_pre", 32'(count_o), 32'h40);
        drive(0, 0, 0, 0, 0, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #3;
        rst_ni = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("arst_idle", 32'(valid_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
